prog_sequencer: RTL and testbench

- Program-level controller directly upstream of the PC/fetch stage.
- Accepts a run request and program select from the bench using a four-phase Req/Done handshake.
- Loads the selected program's start address into the PC, holds the PC via Start, then releases it.
- Watches for the halt instruction, counts execution cycles and flags runaway programs with a timeout.

---
 rtl/prog_sequencer.sv | 149 ++++++++++++++
 tb/tb_prog_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Program-level sequencer ahead of the PC/fetch stage: loads a program's start address,
// holds fetch for a fixed number of cycles, then runs until Halt or a cycle-count timeout.
module prog_sequencer #(
  parameter int unsigned PC_W        = 11,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BASE0       = 0,
  parameter int unsigned BASE1       = 256,
  parameter int unsigned BASE2       = 512,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned MAX_CYCLES  = 4096
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  input  logic [PC_W-1:0]  ProgCtr,
  output logic             Start,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcLoadVal,
  output logic             Busy,
  output logic             Done,
  output logic             TimeoutErr,
  output logic             SelErr,
  output logic [1:0]       ProgId,
  output logic [CNT_W-1:0] CycleCount,
  output logic [PC_W-1:0]  HaltPc
);

  localparam int unsigned HOLD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]         prog_id_q, prog_id_d;
  logic [PC_W-1:0]    pc_load_val_q, pc_load_val_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [PC_W-1:0]    halt_pc_q, halt_pc_d;
  logic               sel_err_q, sel_err_d;
  logic               sel_lock_q, sel_lock_d;
  logic               accept;
  logic [PC_W-1:0]    base_addr;

  assign accept = (state_q == S_IDLE) && Req && (ProgSel != 2'd3);

  always_comb begin
    base_addr = PC_W'(BASE0);
    case (ProgSel)
      2'd1:    base_addr = PC_W'(BASE1);
      2'd2:    base_addr = PC_W'(BASE2);
      default: base_addr = PC_W'(BASE0);
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      prog_id_q     <= '0;
      pc_load_val_q <= '0;
      cycle_cnt_q   <= '0;
      halt_pc_q     <= '0;
      sel_err_q     <= 1'b0;
      sel_lock_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      prog_id_q     <= prog_id_d;
      pc_load_val_q <= pc_load_val_d;
      cycle_cnt_q   <= cycle_cnt_d;
      halt_pc_q     <= halt_pc_d;
      sel_err_q     <= sel_err_d;
      sel_lock_q    <= sel_lock_d;
    end
  end

  // Next-state logic; Halt wins over timeout in the same RUN cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_HOLD;
      S_HOLD:  if (hold_cnt_q == '0) state_d = S_RUN;
      S_RUN: begin
        if (Halt)                                            state_d = S_DONE;
        else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1))      state_d = S_FAULT;
      end
      S_DONE, S_FAULT: if (!Req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; SelErr re-arms only after Req is seen low
  always_comb begin
    hold_cnt_d    = hold_cnt_q;
    prog_id_d     = prog_id_q;
    pc_load_val_d = pc_load_val_q;
    cycle_cnt_d   = cycle_cnt_q;
    halt_pc_d     = halt_pc_q;
    sel_err_d     = (state_q == S_IDLE) && Req && (ProgSel == 2'd3) && !sel_lock_q;
    sel_lock_d    = sel_lock_q;

    if (!Req)           sel_lock_d = 1'b0;
    else if (sel_err_d) sel_lock_d = 1'b1;

    if (accept) begin
      prog_id_d     = ProgSel;
      pc_load_val_d = base_addr;
    end

    case (state_q)
      S_LOAD: begin
        cycle_cnt_d = '0;
        hold_cnt_d  = HOLD_W'(HOLD_CYCLES - 1);
      end
      S_HOLD: if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      S_RUN: begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (Halt) halt_pc_d = ProgCtr;
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    Start      = (state_q != S_RUN);
    PcLoad     = (state_q == S_LOAD);
    Busy       = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);
    Done       = (state_q == S_DONE) || (state_q == S_FAULT);
    TimeoutErr = (state_q == S_FAULT);
  end

  assign PcLoadVal  = pc_load_val_q;
  assign SelErr     = sel_err_q;
  assign ProgId     = prog_id_q;
  assign CycleCount = cycle_cnt_q;
  assign HaltPc     = halt_pc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: stimulus queues expected load/completion/select-error
// events, a negedge monitor pops and compares them as the DUT presents each one.
module tb_prog_sequencer;

  localparam int unsigned PC_W  = 11;
  localparam int unsigned CNT_W = 16;
  localparam int          MAXC  = 4096;

  localparam int EV_LOAD = 0;
  localparam int EV_DONE = 1;
  localparam int EV_SERR = 2;

  typedef struct {
    int               kind;
    logic [PC_W-1:0]  val;
    logic             to;
    logic [CNT_W-1:0] cnt;
    logic [PC_W-1:0]  hpc;
    logic [1:0]       pid;
  } exp_t;

  logic             Clk = 1'b0;
  logic             Reset, Req, Halt;
  logic [1:0]       ProgSel;
  logic [PC_W-1:0]  ProgCtr;
  logic             Start, PcLoad, Busy, Done, TimeoutErr, SelErr;
  logic [PC_W-1:0]  PcLoadVal, HaltPc;
  logic [1:0]       ProgId;
  logic [CNT_W-1:0] CycleCount;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [PC_W-1:0] exp_haltpc = '0;
  logic done_prev = 1'b0;

  prog_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ProgSel(ProgSel), .Halt(Halt), .ProgCtr(ProgCtr),
    .Start(Start), .PcLoad(PcLoad), .PcLoadVal(PcLoadVal), .Busy(Busy), .Done(Done),
    .TimeoutErr(TimeoutErr), .SelErr(SelErr), .ProgId(ProgId), .CycleCount(CycleCount),
    .HaltPc(HaltPc)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Monitor: every presented event must match the head of the scoreboard
  always @(negedge Clk) begin
    exp_t e;
    if (PcLoad === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_pcload", 32'(PcLoadVal), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("load_kind", 32'(EV_LOAD), 32'(e.kind));
        chk("pcloadval", 32'(PcLoadVal), 32'(e.val));
      end
    end
    if (SelErr === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_selerr", 32'(SelErr), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("selerr_kind", 32'(EV_SERR), 32'(e.kind));
      end
    end
    if (Done === 1'b1 && !done_prev) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'(Done), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("done_kind", 32'(EV_DONE), 32'(e.kind));
        chk("timeouterr", 32'(TimeoutErr), 32'(e.to));
        chk("cyclecount", 32'(CycleCount), 32'(e.cnt));
        chk("haltpc", 32'(HaltPc), 32'(e.hpc));
        chk("progid", 32'(ProgId), 32'(e.pid));
        chk("start_in_done", 32'(Start), 32'd1);
      end
    end
    done_prev = (Done === 1'b1);
  end

  // One run from IDLE; halt_at=0 means Halt never comes. Leaves Req high in DONE/FAULT.
  task automatic run_prog(input logic [1:0] sel, input int halt_at, input logic [PC_W-1:0] pc,
                          input logic hold_halt);
    exp_t e;
    logic [PC_W-1:0] base;
    base = (sel == 2'd0) ? 11'd0 : (sel == 2'd1) ? 11'd256 : 11'd512;
    e = '{kind: EV_LOAD, val: base, to: 1'b0, cnt: '0, hpc: '0, pid: '0};
    exp_q.push_back(e);
    if (halt_at > 0) begin
      exp_haltpc = pc;
      e = '{kind: EV_DONE, val: '0, to: 1'b0, cnt: CNT_W'(halt_at), hpc: pc, pid: sel};
    end else begin
      e = '{kind: EV_DONE, val: '0, to: 1'b1, cnt: CNT_W'(MAXC), hpc: exp_haltpc, pid: sel};
    end
    exp_q.push_back(e);

    Req = 1'b1; ProgSel = sel; Halt = 1'b0;
    cyc(1);  // LOAD
    chk("load_start", 32'(Start), 32'd1);
    chk("load_busy", 32'(Busy), 32'd1);
    Halt = hold_halt; ProgCtr = 11'd1500;
    cyc(1);  // HOLD 1
    chk("hold1_start", 32'(Start), 32'd1);
    chk("hold1_busy", 32'(Busy), 32'd1);
    chk("hold1_pcload", 32'(PcLoad), 32'd0);
    cyc(1);  // HOLD 2
    chk("hold2_start", 32'(Start), 32'd1);
    cyc(1);  // RUN 1
    chk("run_start", 32'(Start), 32'd0);
    chk("run_busy", 32'(Busy), 32'd1);
    for (int r = 1; r <= MAXC; r++) begin
      Halt    = (r == halt_at);
      ProgCtr = (r == halt_at) ? pc : PC_W'(r);
      cyc(1);
      if (r == halt_at) break;
    end
    Halt = 1'b0;
    chk("end_done", 32'(Done), 32'd1);
    chk("end_busy", 32'(Busy), 32'd0);
  endtask

  task automatic release_req();
    Req = 1'b0;
    cyc(1);
    chk("idle_done", 32'(Done), 32'd0);
    chk("idle_timeout", 32'(TimeoutErr), 32'd0);
    chk("idle_start", 32'(Start), 32'd1);
  endtask

  initial begin
    exp_t e;
    Reset = 1'b1; Req = 1'b0; ProgSel = 2'd0; Halt = 1'b0; ProgCtr = '0;
    cyc(2);
    chk("rst_start", 32'(Start), 32'd1);
    chk("rst_pcload", 32'(PcLoad), 32'd0);
    chk("rst_pcloadval", 32'(PcLoadVal), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_timeout", 32'(TimeoutErr), 32'd0);
    chk("rst_selerr", 32'(SelErr), 32'd0);
    chk("rst_progid", 32'(ProgId), 32'd0);
    chk("rst_cyclecount", 32'(CycleCount), 32'd0);
    chk("rst_haltpc", 32'(HaltPc), 32'd0);
    Reset = 1'b0;
    cyc(1);

    run_prog(2'd1, 3, 11'd300, 1'b0);
    release_req();
    run_prog(2'd0, 10, 11'd37, 1'b0);
    chk("p0_haltpc_hold", 32'(HaltPc), 32'd37);
    release_req();
    run_prog(2'd2, 0, 11'd0, 1'b0);
    chk("fault_timeout", 32'(TimeoutErr), 32'd1);
    release_req();
    run_prog(2'd2, MAXC, 11'd1234, 1'b0);
    chk("lastcycle_timeout", 32'(TimeoutErr), 32'd0);
    release_req();

    // Invalid select held for five cycles: one SelErr pulse only
    e = '{kind: EV_SERR, val: '0, to: 1'b0, cnt: '0, hpc: '0, pid: '0};
    exp_q.push_back(e);
    Req = 1'b1; ProgSel = 2'd3;
    cyc(5);
    chk("sel3_busy", 32'(Busy), 32'd0);
    chk("sel3_selerr_low", 32'(SelErr), 32'd0);
    Req = 1'b0;
    cyc(1);

    // Reset during RUN cycle 7
    e = '{kind: EV_LOAD, val: 11'd512, to: 1'b0, cnt: '0, hpc: '0, pid: '0};
    exp_q.push_back(e);
    Req = 1'b1; ProgSel = 2'd2;
    cyc(4);
    cyc(6);
    chk("midrun_count", 32'(CycleCount), 32'd6);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0; Req = 1'b0;
    exp_haltpc = '0;
    chk("midrst_start", 32'(Start), 32'd1);
    chk("midrst_count", 32'(CycleCount), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_haltpc", 32'(HaltPc), 32'd0);
    cyc(1);
    run_prog(2'd1, 4, 11'd99, 1'b0);
    release_req();

    // Req held through DONE, Halt outside RUN must not disturb HaltPc
    run_prog(2'd0, 5, 11'd77, 1'b0);
    Halt = 1'b1; ProgCtr = 11'd500;
    cyc(3);
    chk("held_done", 32'(Done), 32'd1);
    chk("held_busy", 32'(Busy), 32'd0);
    Req = 1'b0;
    cyc(2);
    chk("idle_halt_busy", 32'(Busy), 32'd0);
    chk("idle_halt_haltpc", 32'(HaltPc), 32'd77);
    Halt = 1'b0;
    run_prog(2'd2, 2, 11'd88, 1'b1);
    release_req();

    cyc(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
